// File: rtl/ex_operand_stage_if.sv
// ID/EX operand bundle: ID-side operands/control, forwarding sources, EX-side ALU outputs.
// Latency: none, wires only; the registered stage lives in ex_operand_stage.
// Backpressure: stall holds the stage, flush loads a bubble; there is no ready handshake.
// Ports: hazard controls (stall/flush), id_* decoded instruction, exmem_*/memwb_* forward
//        sources, ex_*/alu_* stage outputs. master = upstream/driver side, slave = stage.
interface ex_operand_stage_if;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic        id_src_a;
  logic        id_src_b;
  logic [5:0]  id_alufun;
  logic        id_sign;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd_addr;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd_addr;
  logic [31:0] memwb_result;
  logic        ex_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;

  modport master (
    output stall, flush, id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_src_a, id_src_b, id_alufun, id_sign, id_rd_addr,
           id_reg_write, exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    input  ex_valid, alu_a, alu_b, alu_fun, alu_sign, ex_store_data, ex_rd_addr,
           ex_reg_write
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_src_a, id_src_b, id_alufun, id_sign, id_rd_addr,
           id_reg_write, exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    output ex_valid, alu_a, alu_b, alu_fun, alu_sign, ex_store_data, ex_rd_addr,
           ex_reg_write
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding feeding the ALU.
// Latency: one cycle from ID to EX outputs; forwarding muxes are combinational.
// Backpressure: stall holds control (data refreshed from forwarding); flush wins and loads a bubble.
// Ports: clk, reset (sync, active-high), bus (ex_operand_stage_if.slave) carrying the ID
//        inputs, hazard controls, forwarding sources and the EX-side ALU outputs.
module ex_operand_stage (
  input  logic                  clk,
  input  logic                  reset,
  ex_operand_stage_if.slave     bus
);

  logic        r_valid;
  logic [4:0]  r_rs_addr;
  logic [4:0]  r_rt_addr;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [4:0]  r_shamt;
  logic        r_src_a;
  logic        r_src_b;
  logic [5:0]  r_alufun;
  logic        r_sign;
  logic [4:0]  r_rd_addr;
  logic        r_reg_write;

  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  // Register $0 is hardwired, so a producer "writing" it must never be forwarded.
  // EX/MEM is the younger producer and therefore wins over MEM/WB.
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (r_rs_addr != 5'd0) begin
      if (bus.exmem_reg_write && (bus.exmem_rd_addr == r_rs_addr))
        w_fwd_rs = bus.exmem_result;
      else if (bus.memwb_reg_write && (bus.memwb_rd_addr == r_rs_addr))
        w_fwd_rs = bus.memwb_result;
    end
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    if (r_rt_addr != 5'd0) begin
      if (bus.exmem_reg_write && (bus.exmem_rd_addr == r_rt_addr))
        w_fwd_rt = bus.exmem_result;
      else if (bus.memwb_reg_write && (bus.memwb_rd_addr == r_rt_addr))
        w_fwd_rt = bus.memwb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_valid     <= 1'b0;
      r_rs_addr   <= 5'd0;
      r_rt_addr   <= 5'd0;
      r_rs_data   <= 32'd0;
      r_rt_data   <= 32'd0;
      r_imm       <= 32'd0;
      r_shamt     <= 5'd0;
      r_src_a     <= 1'b0;
      r_src_b     <= 1'b0;
      r_alufun    <= 6'd0;
      r_sign      <= 1'b0;
      r_rd_addr   <= 5'd0;
      r_reg_write <= 1'b0;
    end else if (bus.stall) begin
      // Capture forwarded operands while held: a MEM/WB producer may retire during
      // the stall and its value would otherwise be gone when the stall releases.
      r_rs_data <= w_fwd_rs;
      r_rt_data <= w_fwd_rt;
    end else begin
      r_valid     <= bus.id_valid;
      r_rs_addr   <= bus.id_rs_addr;
      r_rt_addr   <= bus.id_rt_addr;
      r_rs_data   <= bus.id_rs_data;
      r_rt_data   <= bus.id_rt_data;
      r_imm       <= bus.id_imm;
      r_shamt     <= bus.id_shamt;
      r_src_a     <= bus.id_src_a;
      r_src_b     <= bus.id_src_b;
      r_alufun    <= bus.id_alufun;
      r_sign      <= bus.id_sign;
      r_rd_addr   <= bus.id_rd_addr;
      r_reg_write <= bus.id_reg_write & bus.id_valid;
    end
  end

  assign bus.alu_a         = r_src_a ? {27'd0, r_shamt} : w_fwd_rs;
  assign bus.alu_b         = r_src_b ? r_imm : w_fwd_rt;
  assign bus.ex_store_data = w_fwd_rt;
  assign bus.alu_fun       = r_alufun;
  assign bus.alu_sign      = r_sign;
  assign bus.ex_rd_addr    = r_rd_addr;
  assign bus.ex_valid      = r_valid;
  assign bus.ex_reg_write  = r_reg_write & r_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the architectural contents of the ID/EX latch.
  logic        m_valid;
  logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic        m_sa, m_sb, m_sign, m_rw;
  logic [5:0]  m_fun;

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return d;
    if (bus.exmem_reg_write && bus.exmem_rd_addr == a) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd_addr == a) return bus.memwb_result;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the model takes the same decision from the same pre-edge inputs.
  task automatic tick();
    logic [31:0] nrs, nrt;
    nrs = ref_fwd(m_rs, m_rsd);
    nrt = ref_fwd(m_rt, m_rtd);
    if (reset || bus.flush) begin
      m_valid = 0; m_rs = 0; m_rt = 0; m_rsd = 0; m_rtd = 0; m_imm = 0; m_shamt = 0;
      m_sa = 0; m_sb = 0; m_fun = 0; m_sign = 0; m_rd = 0; m_rw = 0;
    end else if (bus.stall) begin
      m_rsd = nrs;
      m_rtd = nrt;
    end else begin
      m_valid = bus.id_valid; m_rs = bus.id_rs_addr; m_rt = bus.id_rt_addr;
      m_rsd = bus.id_rs_data; m_rtd = bus.id_rt_data; m_imm = bus.id_imm;
      m_shamt = bus.id_shamt; m_sa = bus.id_src_a; m_sb = bus.id_src_b;
      m_fun = bus.id_alufun; m_sign = bus.id_sign; m_rd = bus.id_rd_addr;
      m_rw = bus.id_reg_write && bus.id_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_a, e_b, e_st;
    #1;
    e_st = ref_fwd(m_rt, m_rtd);
    e_a  = m_sa ? 32'(m_shamt) : ref_fwd(m_rs, m_rsd);
    e_b  = m_sb ? m_imm : e_st;
    chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(m_valid));
    chk({tag, ".ex_reg_write"}, 32'(bus.ex_reg_write), 32'(m_rw && m_valid));
    chk({tag, ".ex_rd_addr"}, 32'(bus.ex_rd_addr), 32'(m_rd));
    chk({tag, ".alu_fun"}, 32'(bus.alu_fun), 32'(m_fun));
    chk({tag, ".alu_sign"}, 32'(bus.alu_sign), 32'(m_sign));
    chk({tag, ".alu_a"}, bus.alu_a, e_a);
    chk({tag, ".alu_b"}, bus.alu_b, e_b);
    chk({tag, ".store"}, bus.ex_store_data, e_st);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                        input logic rw);
    bus.id_valid = v; bus.id_rs_addr = rs; bus.id_rs_data = rsd;
    bus.id_rt_addr = rt; bus.id_rt_data = rtd; bus.id_rd_addr = rd; bus.id_reg_write = rw;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] ea, input logic [31:0] er,
                         input logic mw, input logic [4:0] ma, input logic [31:0] mr);
    bus.exmem_reg_write = ew; bus.exmem_rd_addr = ea; bus.exmem_result = er;
    bus.memwb_reg_write = mw; bus.memwb_rd_addr = ma; bus.memwb_result = mr;
  endtask

  initial begin
    checks = 0; failures = 0;
    m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_shamt = 0; m_rsd = 0; m_rtd = 0;
    m_imm = 0; m_sa = 0; m_sb = 0; m_sign = 0; m_rw = 0; m_fun = 0;

    // Reset with nonzero ID inputs.
    reset = 1; bus.stall = 0; bus.flush = 0;
    set_id(1, 5'd7, 32'h1234, 5'd6, 32'h5678, 5'd9, 1);
    bus.id_imm = 32'hDEAD; bus.id_shamt = 5'd3; bus.id_src_a = 0; bus.id_src_b = 0;
    bus.id_alufun = 6'h2A; bus.id_sign = 1;
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();
    check_all("reset");
    chk("reset.alu_a_zero", bus.alu_a, 32'd0);

    // Plain load, no forwarding hits.
    reset = 0;
    set_id(1, 5'd8, 32'd5, 5'd9, 32'd7, 5'd10, 1);
    bus.id_alufun = 6'd0; bus.id_sign = 0;
    tick();
    check_all("load");
    chk("load.a5", bus.alu_a, 32'd5);
    chk("load.b7", bus.alu_b, 32'd7);
    chk("load.rd", 32'(bus.ex_rd_addr), 32'd10);

    // Both forwarding sources hit rs=$8: EX/MEM wins, then MEM/WB alone.
    bus.stall = 1;
    set_fwd(1, 5'd8, 32'h11, 1, 5'd8, 32'h22);
    #1 chk("dbl.exmem", bus.alu_a, 32'h11);
    bus.exmem_reg_write = 0;
    #1 chk("dbl.memwb", bus.alu_a, 32'h22);
    bus.stall = 0;
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd0, 32'h33, 5'd9, 32'd7, 5'd10, 1);
    tick();
    set_fwd(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
    check_all("zero_addr");
    chk("zero_addr.a", bus.alu_a, 32'h33);

    // Stall while the MEM/WB producer of rt=$3 retires.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd1, 32'd1, 5'd3, 32'd0, 5'd4, 1);
    tick();
    bus.stall = 1;
    set_fwd(0, 0, 0, 1, 5'd3, 32'hABCD);
    check_all("stall_hit");
    tick();
    set_fwd(0, 0, 0, 0, 5'd3, 32'h0);
    check_all("stall_retired");
    chk("stall_retired.b", bus.alu_b, 32'hABCD);
    chk("stall_retired.st", bus.ex_store_data, 32'hABCD);

    // Flush beats stall.
    bus.flush = 1;
    set_id(1, 5'd2, 32'd9, 5'd5, 32'd9, 5'd12, 1);
    tick();
    check_all("flush");
    chk("flush.valid", 32'(bus.ex_valid), 32'd0);
    chk("flush.rd", 32'(bus.ex_rd_addr), 32'd0);

    // Bubble with reg_write high must not write.
    bus.flush = 0; bus.stall = 0;
    set_id(0, 5'd2, 32'd9, 5'd5, 32'd9, 5'd12, 1);
    tick();
    check_all("bubble");
    chk("bubble.rw", 32'(bus.ex_reg_write), 32'd0);

    // Immediate / shamt select with forwarded rt.
    set_id(1, 5'd2, 32'd9, 5'd4, 32'd0, 5'd6, 1);
    bus.id_src_a = 1; bus.id_shamt = 5'd31; bus.id_src_b = 1; bus.id_imm = 32'hFFFF8000;
    tick();
    set_fwd(1, 5'd4, 32'h5, 0, 0, 0);
    check_all("imm");
    chk("imm.a", bus.alu_a, 32'h1F);
    chk("imm.b", bus.alu_b, 32'hFFFF8000);
    chk("imm.st", bus.ex_store_data, 32'h5);

    // Reset during stall.
    bus.stall = 1; reset = 1;
    tick();
    reset = 0;
    check_all("reset_stall");
    chk("reset_stall.valid", 32'(bus.ex_valid), 32'd0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 31) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      set_id(1'($urandom), 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)),
             $urandom, 5'($urandom), 1'($urandom));
      bus.id_imm = $urandom; bus.id_shamt = 5'($urandom);
      bus.id_src_a = 1'($urandom); bus.id_src_b = 1'($urandom);
      bus.id_alufun = 6'($urandom); bus.id_sign = 1'($urandom);
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      tick();
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and EX-stage operand selection for the 5-stage pipelined CPU. Latches decoded operands and control from ID, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the A, B, ALUFun and Sign inputs of the EX-stage ALU. Supports stall (hold) and flush (bubble insertion) from the hazard/branch logic.

## Interface
Parameters: none (datapath fixed at 32 bits, register addresses 5 bits).

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold current contents
- flush  in  1  load a bubble; priority over stall
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr  in  5  source register numbers
- id_rs_data, id_rt_data  in  32  register file read data (write-through already applied in ID)
- id_imm  in  32  extended immediate
- id_shamt  in  5  shift amount field
- id_src_a  in  1  0: A = rs, 1: A = {27'b0, shamt}
- id_src_b  in  1  0: B = rt, 1: B = imm
- id_alufun  in  6  ALU function code
- id_sign  in  1  signed compare select
- id_rd_addr  in  5  destination register
- id_reg_write  in  1  instruction writes rd
- exmem_reg_write, exmem_rd_addr, exmem_result  in  1/5/32  EX/MEM forwarding source
- memwb_reg_write, memwb_rd_addr, memwb_result  in  1/5/32  MEM/WB forwarding source
- ex_valid  out  1  EX holds a real instruction
- alu_a, alu_b  out  32  ALU operands (forwarded)
- alu_fun  out  6  ALU function code
- alu_sign  out  1  signed compare select
- ex_store_data  out  32  forwarded rt value (store data)
- ex_rd_addr  out  5  destination register
- ex_reg_write  out  1  write enable, gated by ex_valid

## Operation
- Stored state: valid, rs/rt addr, rs/rt data, imm, shamt, src_a, src_b, alufun, sign, rd_addr, reg_write.
- Update priority per edge: reset > flush > stall > load.
  - reset or flush: all stored fields to 0 (bubble: valid=0, reg_write=0, rd=0, alufun=000000).
  - stall: control fields held; rs/rt data fields overwritten with their forwarded values (fwd_rs, fwd_rt below) so a MEM/WB value is not lost when the producer retires during the stall.
  - load: all fields from id_*; valid=id_valid; reg_write=id_reg_write & id_valid.
- Forwarding (combinational on stored addr/data, per operand X in {rs, rt}):
  - addr==0: stored data, never forwarded.
  - exmem_reg_write & exmem_rd_addr==addr: exmem_result (highest priority).
  - else memwb_reg_write & memwb_rd_addr==addr: memwb_result.
  - else stored data.
- alu_a = src_a ? {27'b0, shamt} : fwd_rs. alu_b = src_b ? imm : fwd_rt. ex_store_data = fwd_rt regardless of src_b.
- alu_fun, alu_sign, ex_rd_addr, ex_valid driven directly from stored fields; ex_reg_write = stored reg_write & stored valid.

## Timing
- Latency: ID inputs present at edge N appear on outputs after edge N (one cycle).
- Forwarding path is combinational from exmem_*/memwb_* to alu_a/alu_b/ex_store_data, same cycle.
- Reset values: ex_valid=0, ex_reg_write=0, ex_rd_addr=0, alu_fun=0, alu_sign=0, alu_a=0, alu_b=0, ex_store_data=0 (forwarding cannot hit addr 0).
- stall and flush both high: flush wins, bubble loaded.
- reset asserted mid-stall: bubble, stall ignored.
- Both forwarding sources match: EX/MEM value used.
- Bubble (valid=0) never asserts ex_reg_write even if id_reg_write was high.

## Test plan
- Reset: drive reset 1 cycle with id_* nonzero -> next cycle ex_valid=0, ex_reg_write=0, alu_a=alu_b=0, alu_fun=0.
- Plain load: rs=$8 data 5, rt=$9 data 7, alufun=000000, no forward hits -> next cycle alu_a=5, alu_b=7, ex_rd_addr=id_rd_addr, ex_valid=1.
- Double hit: stored rs=$8; exmem writes $8=0x11, memwb writes $8=0x22 -> alu_a=0x11; drop exmem_reg_write -> alu_a=0x22; set addr $0 with both hitting $0 -> alu_a=stored data.
- Stall with retiring producer: stored rt=$3 data 0; memwb writes $3=0xABCD during stall cycle; next cycle memwb no longer matches, stall still high -> alu_b and ex_store_data = 0xABCD.
- Flush vs stall: stall=1, flush=1, valid instruction in ID -> next cycle ex_valid=0, ex_reg_write=0, ex_rd_addr=0.
- Immediate/shamt select: src_a=1 shamt=31, src_b=1 imm=0xFFFF8000, rt forwarded 0x5 -> alu_a=0x1F, alu_b=0xFFFF8000, ex_store_data=0x5.
